// File: rtl/fb_bank_ring_pkg.sv
// Shared definitions for the frame-buffer bank ring: write FSM encoding and
// sticky error flag positions.
package fb_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wr_state_t;

  localparam int unsigned ERR_W         = 4;
  localparam int unsigned ERR_BURST_LEN = 0;
  localparam int unsigned ERR_UNDERFLOW = 1;
  localparam int unsigned ERR_IDLE_WR   = 2;
  localparam int unsigned ERR_OVERFLOW  = 3;
endpackage

// File: rtl/fb_bank_ring_if.sv
// Write-burst, read and status signals of the bank ring, grouped for the
// producer/consumer side (master) and the buffer itself (slave).
interface fb_bank_ring_if
  import fb_pkg::*;
#(
  parameter int unsigned RD_W     = 32,
  parameter int unsigned WR_RATIO = 2,
  parameter int unsigned NBANKS   = 2
);
  localparam int unsigned FB_W = $clog2(NBANKS + 1);

  logic                     frame_sync;
  logic                     burst_ready;
  logic                     burst_start;
  logic                     wr_en;
  logic [RD_W*WR_RATIO-1:0] wr_data;
  logic                     burst_end;
  logic                     rd_en;
  logic [RD_W-1:0]          rd_data;
  logic                     rd_valid;
  logic                     rd_empty;
  logic                     bank_swap;
  logic [FB_W-1:0]          full_banks;
  logic [ERR_W-1:0]         error;

  modport master (
    output frame_sync, burst_start, wr_en, wr_data, burst_end, rd_en,
    input  burst_ready, rd_data, rd_valid, rd_empty, bank_swap, full_banks, error
  );

  modport slave (
    input  frame_sync, burst_start, wr_en, wr_data, burst_end, rd_en,
    output burst_ready, rd_data, rd_valid, rd_empty, bank_swap, full_banks, error
  );
endinterface

// File: rtl/fb_bank_ring_ram.sv
// Simple dual-port RAM holding write-width words; the registered read word is
// narrowed to one read-width slice selected by the address captured with it.
module fb_bank_ram #(
  parameter int unsigned RD_W     = 32,
  parameter int unsigned WR_RATIO = 2,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned AW       = 10,
  parameter int unsigned SELW     = 1
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [RD_W*WR_RATIO-1:0] wdata,
  input  logic                     re,
  input  logic [AW-1:0]            raddr,
  input  logic [SELW-1:0]          rsel,
  output logic [RD_W-1:0]          rdata
);
  logic [RD_W*WR_RATIO-1:0] mem [DEPTH];
  logic [RD_W*WR_RATIO-1:0] word_q;
  logic [SELW-1:0]          sel_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) begin
      word_q <= mem[raddr];
      sel_q  <= rsel;
    end
  end

  assign rdata = word_q[RD_W*sel_q +: RD_W];
endmodule

// File: rtl/fb_bank_ring.sv
// Multi-bank ring buffer: bursts of wide words fill banks in turn, the reader
// drains whole banks one narrow word at a time.
module fb_bank_ring
  import fb_pkg::*;
#(
  parameter int unsigned RD_W       = 32,
  parameter int unsigned WR_RATIO   = 2,
  parameter int unsigned BANK_DEPTH = 1024,
  parameter int unsigned NBANKS     = 2,
  parameter int unsigned BURST_LEN  = 16
) (
  input logic          rclk,
  input logic          reset,
  fb_bank_ring_if.slave bus
);
  localparam int unsigned WDEPTH = BANK_DEPTH / WR_RATIO;
  localparam int unsigned WAW    = (WDEPTH > 1) ? $clog2(WDEPTH) : 1;
  localparam int unsigned RAW    = $clog2(BANK_DEPTH);
  localparam int unsigned BW     = $clog2(NBANKS);
  localparam int unsigned FW     = $clog2(NBANKS + 1);
  localparam int unsigned SELW   = (WR_RATIO > 1) ? $clog2(WR_RATIO) : 1;
  localparam int unsigned BCW    = $clog2(BURST_LEN + 2);

  wr_state_t        state, state_n;
  logic [BW-1:0]    wbank, rbank;
  logic [WAW-1:0]   waddr;
  logic [RAW-1:0]   raddr;
  logic [FW-1:0]    full, full_n;
  logic [BCW-1:0]   beats, beats_n;
  logic [ERR_W-1:0] err;
  logic             ready, rd_valid_q, swap_q;
  logic             not_full, wr_ok, rd_ok, fill, retire;
  logic [SELW-1:0]  rsel;

  assign not_full = (full != FW'(NBANKS));
  assign wr_ok    = (state == ST_BURST) && bus.wr_en && not_full && !bus.frame_sync;
  assign rd_ok    = bus.rd_en && (full != '0) && !bus.frame_sync;
  assign fill     = wr_ok && (waddr == WAW'(WDEPTH - 1));
  assign retire   = rd_ok && (raddr == RAW'(BANK_DEPTH - 1));
  assign rsel     = (WR_RATIO > 1) ? raddr[SELW-1:0] : '0;

  // Beat count saturates one past BURST_LEN so overlong bursts stay flagged.
  always_comb begin
    beats_n = beats;
    if (wr_ok && beats != BCW'(BURST_LEN + 1)) beats_n = beats + BCW'(1);
  end

  always_comb begin
    full_n  = full;
    state_n = state;
    if (bus.frame_sync) begin
      full_n  = '0;
      state_n = ST_IDLE;
    end else begin
      if (fill && !retire)      full_n = full + FW'(1);
      else if (retire && !fill) full_n = full - FW'(1);
      case (state)
        ST_IDLE:  if (bus.burst_start) state_n = ST_BURST;
        ST_BURST: if (bus.burst_end)   state_n = ST_IDLE;
        default:  state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wbank      <= '0;
      rbank      <= '0;
      waddr      <= '0;
      raddr      <= '0;
      full       <= '0;
      beats      <= '0;
      err        <= '0;
      ready      <= 1'b1;
      rd_valid_q <= 1'b0;
      swap_q     <= 1'b0;
    end else begin
      state      <= state_n;
      full       <= full_n;
      ready      <= (state_n == ST_IDLE) && (full_n != FW'(NBANKS));
      rd_valid_q <= rd_ok;
      swap_q     <= retire;
      if (bus.frame_sync) begin
        wbank <= '0;
        rbank <= '0;
        waddr <= '0;
        raddr <= '0;
      end else begin
        if (wr_ok) begin
          waddr <= waddr + WAW'(1);
          if (fill) wbank <= (wbank == BW'(NBANKS - 1)) ? '0 : wbank + BW'(1);
        end
        if (rd_ok) begin
          raddr <= raddr + RAW'(1);
          if (retire) rbank <= (rbank == BW'(NBANKS - 1)) ? '0 : rbank + BW'(1);
        end
        beats <= (state == ST_IDLE && bus.burst_start) ? '0 : beats_n;
        if (state == ST_BURST && bus.burst_end && beats_n != BCW'(BURST_LEN))
          err[ERR_BURST_LEN] <= 1'b1;
        if (bus.rd_en && full == '0)      err[ERR_UNDERFLOW] <= 1'b1;
        if (bus.wr_en && state == ST_IDLE) err[ERR_IDLE_WR]  <= 1'b1;
        if (bus.wr_en && !not_full)        err[ERR_OVERFLOW] <= 1'b1;
      end
    end
  end

  fb_bank_ram #(
    .RD_W    (RD_W),
    .WR_RATIO(WR_RATIO),
    .DEPTH   (NBANKS * WDEPTH),
    .AW      (BW + WAW),
    .SELW    (SELW)
  ) u_ram (
    .clk  (rclk),
    .we   (wr_ok),
    .waddr({wbank, waddr}),
    .wdata(bus.wr_data),
    .re   (rd_ok),
    .raddr({rbank, raddr[RAW-1 -: WAW]}),
    .rsel (rsel),
    .rdata(bus.rd_data)
  );

  assign bus.burst_ready = ready;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_empty    = (full == '0);
  assign bus.bank_swap   = swap_q;
  assign bus.full_banks  = full;
  assign bus.error       = err;
endmodule

// File: tb/tb_fb_bank_ring.sv
// Bench for fb_bank_ring: directed table, multi-cycle scenarios and random
// traffic, all checked against an array-based reference model.
module tb_fb_bank_ring;
  localparam int unsigned RD_W       = 32;
  localparam int unsigned WR_RATIO   = 2;
  localparam int unsigned BANK_DEPTH = 1024;
  localparam int unsigned NBANKS     = 2;
  localparam int unsigned BURST_LEN  = 16;
  localparam int unsigned WDEPTH     = BANK_DEPTH / WR_RATIO;

  logic rclk  = 1'b0;
  logic reset = 1'b1;
  always #5 rclk = ~rclk;

  fb_bank_ring_if #(.RD_W(RD_W), .WR_RATIO(WR_RATIO), .NBANKS(NBANKS)) bus ();

  fb_bank_ring #(
    .RD_W      (RD_W),
    .WR_RATIO  (WR_RATIO),
    .BANK_DEPTH(BANK_DEPTH),
    .NBANKS    (NBANKS),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .rclk (rclk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_burst;
  int          m_beats, m_wb, m_wa, m_rb, m_ra, m_full;
  logic [3:0]  m_err;
  logic        m_rv, m_swap;
  logic [31:0] m_rdata;
  logic [31:0] mem [NBANKS*BANK_DEPTH];

  typedef struct {
    logic fs, bs, we, be, re;
    logic br, empty, rv;
    logic [3:0] err;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic fs, input logic bs, input logic we,
                            input logic be, input logic re, input logic [63:0] wd);
    bit fill, retire, wr_ok, rd_ok;
    if (rst) begin
      m_burst = 0; m_beats = 0; m_wb = 0; m_wa = 0; m_rb = 0; m_ra = 0; m_full = 0;
      m_err = '0; m_rv = 0; m_swap = 0;
      return;
    end
    m_rv = 0; m_swap = 0;
    if (fs) begin
      m_burst = 0; m_wb = 0; m_wa = 0; m_rb = 0; m_ra = 0; m_full = 0;
      return;
    end
    if (we && !m_burst) m_err[2] = 1'b1;
    if (we && m_full == NBANKS) m_err[3] = 1'b1;
    if (re && m_full == 0) m_err[1] = 1'b1;
    wr_ok = m_burst && we && (m_full < NBANKS);
    rd_ok = re && (m_full > 0);
    fill = 0; retire = 0;
    if (rd_ok) begin
      m_rdata = mem[m_rb*BANK_DEPTH + m_ra];
      m_rv = 1;
      m_ra++;
      if (m_ra == BANK_DEPTH) begin m_ra = 0; m_rb = (m_rb + 1) % NBANKS; retire = 1; end
      m_swap = retire;
    end
    if (wr_ok) begin
      for (int unsigned k = 0; k < WR_RATIO; k++)
        mem[m_wb*BANK_DEPTH + m_wa*WR_RATIO + k] = wd[k*RD_W +: RD_W];
      m_beats++;
      m_wa++;
      if (m_wa == WDEPTH) begin m_wa = 0; m_wb = (m_wb + 1) % NBANKS; fill = 1; end
    end
    m_full = m_full + int'(fill) - int'(retire);
    if (m_burst && be) begin
      if (m_beats != BURST_LEN) m_err[0] = 1'b1;
      m_burst = 0;
    end else if (!m_burst && bs) begin
      m_burst = 1;
      m_beats = 0;
    end
  endtask

  task automatic cycle(input logic fs, input logic bs, input logic we, input logic be,
                       input logic re, input logic [63:0] wd);
    bus.frame_sync  = fs;
    bus.burst_start = bs;
    bus.wr_en       = we;
    bus.burst_end   = be;
    bus.rd_en       = re;
    bus.wr_data     = wd;
    @(posedge rclk);
    #1;
    model_step(reset, fs, bs, we, be, re, wd);
    chk("burst_ready", bus.burst_ready, 64'(!m_burst && m_full < NBANKS));
    chk("rd_empty", bus.rd_empty, 64'(m_full == 0));
    chk("full_banks", bus.full_banks, 64'(m_full));
    chk("error", bus.error, m_err);
    chk("rd_valid", bus.rd_valid, m_rv);
    chk("bank_swap", bus.bank_swap, m_swap);
    if (m_rv) chk("rd_data", bus.rd_data, m_rdata);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(0, 0, 0, 0, 0, '0);
    reset = 1'b0;
  endtask

  function automatic logic [63:0] wword(input logic [31:0] base, input int n);
    return {base ^ 32'(2*n + 1), base ^ 32'(2*n)};
  endfunction

  task automatic write_bursts(input logic [31:0] base, input int nb);
    for (int b = 0; b < nb; b++) begin
      cycle(0, 1, 0, 0, 0, '0);
      for (int i = 0; i < int'(BURST_LEN); i++) cycle(0, 0, 1, 0, 0, wword(base, b*16 + i));
      cycle(0, 0, 0, 1, 0, '0);
    end
  endtask

  task automatic read_words(input logic [31:0] base, input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      cycle(0, 0, 0, 0, 1, '0);
      chk("rd_order", bus.rd_data, base ^ 32'(k));
    end
  endtask

  initial begin
    logic fs, bs, we, be, re;
    bus.frame_sync = 0; bus.burst_start = 0; bus.wr_en = 0;
    bus.burst_end = 0; bus.rd_en = 0; bus.wr_data = '0;

    // Reset state
    do_reset();
    chk("rst_burst_ready", bus.burst_ready, 1);
    chk("rst_rd_empty", bus.rd_empty, 1);
    chk("rst_error", bus.error, 0);

    // Protocol-error table from a fresh reset
    tbl[0] = '{0,0,0,0,1, 1,1,0, 4'b0010};
    tbl[1] = '{0,0,1,0,0, 1,1,0, 4'b0110};
    tbl[2] = '{0,0,0,1,0, 1,1,0, 4'b0110};
    tbl[3] = '{0,1,0,0,0, 0,1,0, 4'b0110};
    tbl[4] = '{0,1,0,0,0, 0,1,0, 4'b0110};
    tbl[5] = '{0,0,1,0,0, 0,1,0, 4'b0110};
    tbl[6] = '{0,0,0,1,0, 1,1,0, 4'b0111};
    tbl[7] = '{0,1,0,0,0, 0,1,0, 4'b0111};
    tbl[8] = '{1,0,0,0,0, 1,1,0, 4'b0111};
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].fs, tbl[i].bs, tbl[i].we, tbl[i].be, tbl[i].re, 64'h1111_2222_3333_4444);
      chk($sformatf("tbl%0d_burst_ready", i), bus.burst_ready, tbl[i].br);
      chk($sformatf("tbl%0d_rd_empty", i), bus.rd_empty, tbl[i].empty);
      chk($sformatf("tbl%0d_rd_valid", i), bus.rd_valid, tbl[i].rv);
      chk($sformatf("tbl%0d_error", i), bus.error, tbl[i].err);
    end

    // Fill bank 0
    do_reset();
    write_bursts(32'hA500_0000, 32);
    chk("fill_full", bus.full_banks, 1);
    chk("fill_ready", bus.burst_ready, 1);
    chk("fill_error", bus.error, 0);

    // Drain bank 0 except the last word; its final read meets bank 1's final beat
    read_words(32'hA500_0000, 0, 1023);
    write_bursts(32'h5A00_0000, 31);
    cycle(0, 1, 0, 0, 0, '0);
    for (int i = 0; i < 15; i++) cycle(0, 0, 1, 0, 0, wword(32'h5A00_0000, 496 + i));
    cycle(0, 0, 1, 0, 1, wword(32'h5A00_0000, 511));
    chk("sim_full", bus.full_banks, 1);
    chk("sim_swap", bus.bank_swap, 1);
    chk("sim_rd_data", bus.rd_data, 32'hA500_0000 ^ 32'd1023);
    cycle(0, 0, 0, 1, 0, '0);
    chk("sim_error", bus.error, 0);

    // Overflow: both banks full, extra beat dropped
    write_bursts(32'h3C00_0000, 32);
    chk("ovf_full", bus.full_banks, 2);
    chk("ovf_ready", bus.burst_ready, 0);
    cycle(0, 1, 0, 0, 0, '0);
    cycle(0, 0, 1, 0, 0, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("ovf_error", bus.error, 4'b1000);
    cycle(0, 0, 0, 1, 0, '0);
    read_words(32'h5A00_0000, 0, 1024);
    chk("rd1_swap", bus.bank_swap, 1);
    read_words(32'h3C00_0000, 0, 1024);
    chk("rd0_swap", bus.bank_swap, 1);
    chk("rd0_empty", bus.rd_empty, 1);
    cycle(0, 0, 0, 0, 0, '0);
    chk("swap_pulse_end", bus.bank_swap, 0);

    // Short burst
    do_reset();
    cycle(0, 1, 0, 0, 0, '0);
    for (int i = 0; i < 15; i++) cycle(0, 0, 1, 0, 0, wword(32'h0F00_0000, i));
    cycle(0, 0, 0, 1, 0, '0);
    chk("short_error", bus.error, 4'b0001);

    // Flush mid-burst with one full bank; same-cycle wr/rd are overridden
    do_reset();
    write_bursts(32'h1200_0000, 32);
    cycle(0, 0, 1, 0, 0, '0);
    cycle(0, 1, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0, wword(32'h3400_0000, i));
    cycle(1, 0, 1, 0, 1, 64'h0);
    chk("flush_full", bus.full_banks, 0);
    chk("flush_empty", bus.rd_empty, 1);
    chk("flush_ready", bus.burst_ready, 1);
    chk("flush_error", bus.error, 4'b0100);
    chk("flush_rd_valid", bus.rd_valid, 0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      fs = ($urandom_range(0, 1999) == 0);
      if (m_burst) begin
        be = (m_beats >= int'(BURST_LEN)) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 59) == 0);
        bs = ($urandom_range(0, 9) == 0);
        we = ($urandom_range(0, 3) != 0);
      end else begin
        bs = ($urandom_range(0, 3) == 0);
        be = ($urandom_range(0, 19) == 0);
        we = ($urandom_range(0, 99) == 0);
      end
      re = 1'($urandom_range(0, 1));
      cycle(fs, bs, we, be, re, {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fb_bank_ring.md
FB_BANK_RING -- requirements
Module: fb_bank_ring

Interface
REQ-001 SHALL have parameter RD_W, default 32, read word width in bits.
REQ-002 SHALL have parameter WR_RATIO, default 2, write width / read width; legal values are 1, 2, 4.
REQ-003 SHALL have parameter BANK_DEPTH, default 1024, read words per bank; power of 2.
REQ-004 SHALL have parameter NBANKS, default 2, bank count; legal range 2..8.
REQ-005 SHALL have parameter BURST_LEN, default 16, write beats per burst; must divide BANK_DEPTH/WR_RATIO.
REQ-006 SHALL have ports (name, direction, width, meaning):
- rclk, in, 1: sole clock.
- reset, in, 1: reset is synchronous and active-high; the clock is rclk.
- frame_sync, in, 1: flush pulse.
- burst_ready, out, 1: a burst may start.
- burst_start, in, 1: burst begins.
- wr_en, in, 1: write beat.
- wr_data, in, RD_W*WR_RATIO: write data.
- burst_end, in, 1: burst closes.
- rd_en, in, 1: read request.
- rd_data, out, RD_W: read data.
- rd_valid, out, 1: rd_data valid.
- rd_empty, out, 1: no full bank available to read.
- bank_swap, out, 1: read bank retired (pulse).
- full_banks, out, clog2(NBANKS+1): count of filled, unread banks.
- error, out, 4: sticky error flags.

Function
REQ-007 SHALL keep write bank pointer wbank, write address waddr (BANK_DEPTH/WR_RATIO words), read bank pointer rbank, and read address raddr (BANK_DEPTH words); bank pointers wrap NBANKS-1 -> 0.
REQ-008 SHALL use a two-state write FSM, IDLE and BURST: burst_start in IDLE -> BURST with beat count 0; burst_end in BURST -> IDLE.
REQ-009 SHALL drive burst_ready = 1 only when FSM = IDLE and full_banks < NBANKS.
REQ-010 SHALL, on wr_en in BURST with full_banks < NBANKS, write wr_data at (wbank, waddr), increment waddr and increment the beat count.
REQ-011 SHALL, when waddr wraps from last word to 0, increment full_banks and advance wbank in the same cycle.
REQ-012 SHALL place write-word slice [RD_W-1:0] at the lowest read address (little-endian unpack).
REQ-013 SHALL, on rd_en with rd_empty = 0, register the word at (rbank, raddr) into rd_data, assert rd_valid exactly 1 cycle later, and increment raddr.
REQ-014 SHALL, when raddr wraps from BANK_DEPTH-1 to 0, decrement full_banks, advance rbank, and pulse bank_swap for 1 cycle.
REQ-015 SHALL leave full_banks unchanged when a fill (REQ-011) and a retire (REQ-014) occur in the same cycle.
REQ-016 SHALL drive rd_empty = (full_banks == 0) combinationally.
REQ-017 SHALL allow reads of a bank in the same cycle that another bank is being written; read-during-write of the same bank cannot occur.
REQ-018 SHALL set error[0] when burst_end arrives with beat count != BURST_LEN (short/long burst); the data written is kept.
REQ-019 SHALL set error[1] on rd_en with rd_empty = 1 (underflow); the request is ignored and rd_valid stays 0.
REQ-020 SHALL set error[2] on wr_en while FSM = IDLE; the beat is dropped.
REQ-021 SHALL set error[3] on wr_en while full_banks == NBANKS (overflow); the beat is dropped.
REQ-022 SHALL, on frame_sync, zero wbank, waddr, rbank, raddr and full_banks, and force FSM = IDLE on the next edge; frame_sync overrides all same-cycle events; error flags are not cleared.
REQ-023 SHALL ignore burst_start while in BURST and burst_end while in IDLE (no error).

Reset
REQ-024 SHALL, on reset, clear all pointers, counters, error, rd_valid, bank_swap and full_banks, and set FSM = IDLE; burst_ready = 1 and rd_empty = 1 in the first cycle after reset.
REQ-025 SHALL NOT reset memory contents; reset asserted mid-burst or mid-read abandons the operation without setting any error flag.

Structure
REQ-026 SHALL take error bit indices and FSM state encoding from a shared package, fb_pkg.
REQ-027 SHALL instantiate one sub-module, fb_bank_ram: a simple dual-port RAM, NBANKS*BANK_DEPTH/WR_RATIO x RD_W*WR_RATIO, with a registered read port and a read-side mux of width WR_RATIO.

Verification
REQ-028 SHALL cover fill: 32 bursts of 16 beats into bank 0 -> full_banks = 1, wbank = 1, burst_ready = 1, error = 0.
REQ-029 SHALL cover read: 1024 rd_en on the filled bank -> word order d[31:0], d[63:32] per write word; bank_swap pulses on read 1024; rd_empty = 1 afterwards.
REQ-030 SHALL cover overflow: fill both banks -> burst_ready = 0; an extra wr_en sets error[3] and memory is unchanged.
REQ-031 SHALL cover simultaneous events: the final write beat of bank 1 coincides with the final read of bank 0 -> full_banks stays 1 and bank_swap = 1.
REQ-032 SHALL cover protocol errors: a 15-beat burst -> error[0]; rd_en on an empty buffer -> error[1] and rd_valid = 0; wr_en in IDLE -> error[2].
REQ-033 SHALL cover flush: frame_sync mid-burst with full_banks = 1 -> next cycle full_banks = 0, rd_empty = 1, burst_ready = 1, error unchanged.
